// File: rtl/max_int_serial_pkg.sv
// Shared types for the bit-serial signed max block.
package max_int_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-index counter width; kept at least one bit wide.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/max_int_serial_bitcmp.sv
// One-bit MSB-first compare cell: latches the first differing bit and reports whether B wins.
module max_int_serial_bitcmp (
    input  logic a,
    input  logic b,
    input  logic is_sign,
    input  logic decided_in,
    output logic decided_out,
    output logic b_gt_out
);

    logic differ;

    assign differ      = (a ^ b) & ~decided_in;
    assign decided_out = decided_in | differ;
    // On the sign bit a set 'a' means A is negative, so B is larger.
    assign b_gt_out    = differ & (is_sign ? a : b);

endmodule

// File: rtl/max_int_serial.sv
// Sequential signed max(A,B) using an MSB-first bit-serial compare.
// Build option: define MAX_INT_SERIAL_EARLY_EXIT_EN to leave the scan as soon as the result is decided.
module max_int_serial
    import max_int_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, y_reg;
    logic [CNT_W-1:0] cnt;
    logic             decided, b_gt, last_bit;
    logic             cmp_exit, is_sign, dec_out, bgt_out;

    assign is_sign = (cnt == CNT_W'(WIDTH-1));

    max_int_serial_bitcmp u_bitcmp (
        .a           (a_reg[cnt]),
        .b           (b_reg[cnt]),
        .is_sign     (is_sign),
        .decided_in  (decided),
        .decided_out (dec_out),
        .b_gt_out    (bgt_out)
    );

`ifdef MAX_INT_SERIAL_EARLY_EXIT_EN
    assign cmp_exit = last_bit || decided;
`else
    assign cmp_exit = last_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CMP;
            CMP:     if (cmp_exit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // last_bit marks that bit 0 has been scanned, giving the extra cycle before DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            y_reg    <= '0;
            cnt      <= '0;
            decided  <= 1'b0;
            b_gt     <= 1'b0;
            last_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        cnt      <= CNT_W'(WIDTH-1);
                        decided  <= 1'b0;
                        b_gt     <= 1'b0;
                        last_bit <= 1'b0;
                    end
                end
                CMP: begin
                    if (cmp_exit) begin
                        y_reg <= b_gt ? b_reg : a_reg;
                    end else begin
                        decided <= dec_out;
                        b_gt    <= b_gt | bgt_out;
                        if (cnt == '0) begin
                            last_bit <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Y = y_reg;

endmodule
